// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit controller with lane handling, req/ack handshake and bus timeout
module lsu_ctrl #(
  parameter int XLEN = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_lsu,
  input  logic [6:0]        opcode_lsu,
  input  logic [2:0]        funct3_lsu,
  input  logic [XLEN-1:0]   addr_lsu,
  input  logic [XLEN-1:0]   wdata_lsu,
  output logic [XLEN-1:0]   rdata_lsu,
  output logic              done_lsu,
  output logic              stall_lsu,
  output logic [1:0]        exc_lsu,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN/8-1:0] mem_be,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_ack
);
  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);
  localparam int CW = $clog2(TIMEOUT + 2);
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;
  state_t state, next;
  logic [XLEN-1:0] addr_q, wdata_q, rdata_q, dmask, sh, ext;
  logic [1:0] sz_q, exc_q, exc_d;
  logic u_q, we_q, is_mem, legal, mis, to;
  logic [CW-1:0] cnt;
  logic [NB-1:0] bmask;
  logic [OW+2:0] bsh;
  assign is_mem = opcode_lsu == OP_LD || opcode_lsu == OP_ST;
  always_comb begin
    legal = funct3_lsu inside {3'b000, 3'b001, 3'b010}
         || (opcode_lsu == OP_LD && funct3_lsu inside {3'b100, 3'b101})
         || (XLEN == 64 && (funct3_lsu == 3'b011 || (opcode_lsu == OP_LD && funct3_lsu == 3'b110)));
    mis = funct3_lsu[1:0] == 2'd1 ? addr_lsu[0]
        : funct3_lsu[1:0] == 2'd2 ? |addr_lsu[1:0]
        : funct3_lsu[1:0] == 2'd3 ? |addr_lsu[2:0] : 1'b0;
    exc_d = !legal ? 2'b11 : mis ? 2'b01 : 2'b00;
    to = TIMEOUT > 0 && cnt == CW'(TIMEOUT);
    next = IDLE;
    if (state == IDLE) next = (valid_lsu && is_mem) ? (|exc_d ? ERR : REQ) : IDLE;
    else if (state == REQ) next = mem_ack ? DONE : to ? ERR : REQ;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      sz_q <= '0;
      exc_q <= '0;
      u_q <= 1'b0;
      we_q <= 1'b0;
    end else begin
      state <= next;
      if (state == IDLE && valid_lsu && is_mem) begin
        addr_q <= addr_lsu;
        wdata_q <= wdata_lsu;
        sz_q <= funct3_lsu[1:0];
        u_q <= funct3_lsu[2];
        we_q <= opcode_lsu == OP_ST;
        exc_q <= exc_d;
        cnt <= '0;
      end
      if (state == REQ) begin
        cnt <= cnt + 1'b1;
        if (mem_ack && !we_q) rdata_q <= ext;
        if (!mem_ack && to) exc_q <= 2'b10;
      end
    end
  end
  // Masks cover the access size; the sign bit is the top bit of the byte mask window.
  always_comb begin
    bsh = {addr_q[OW-1:0], 3'b000};
    dmask = ~({XLEN{1'b1}} << (8 << sz_q));
    bmask = ~({NB{1'b1}} << (1 << sz_q));
    sh = mem_rdata >> bsh;
    ext = (sh & dmask) | ((!u_q && |(sh & (dmask ^ (dmask >> 1)))) ? ~dmask : '0);
  end
  assign mem_req = state == REQ;
  assign mem_we = mem_req && we_q;
  assign mem_addr = mem_req ? {addr_q[XLEN-1:OW], OW'(0)} : '0;
  assign mem_be = mem_req ? bmask << addr_q[OW-1:0] : '0;
  assign mem_wdata = mem_req ? (wdata_q & dmask) << bsh : '0;
  assign rdata_lsu = rdata_q;
  assign done_lsu = state == DONE || state == ERR;
  assign exc_lsu = state == ERR ? exc_q : 2'b00;
  assign stall_lsu = (state == IDLE && valid_lsu && is_mem) || state == REQ;
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: table-driven and randomized checks of lsu_ctrl against a byte-level model
module tb_lsu_ctrl;
  localparam int TO = 4;
  localparam logic [6:0] LD = 7'h03, ST = 7'h23, ADD = 7'h33;
  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic [31:0] addr, wdata, rdata;
    int delay;
    logic [3:0] be;
    logic [31:0] wd, rd;
    logic [1:0] exc;
    int nreq, done;
  } vec_t;
  logic clk = 0, rst = 1, valid_lsu = 0, mem_ack = 0;
  logic [6:0] opcode_lsu = 0;
  logic [2:0] funct3_lsu = 0;
  logic [31:0] addr_lsu = 0, wdata_lsu = 0, mem_rdata = 0;
  logic [31:0] rdata_lsu, mem_addr, mem_wdata;
  logic done_lsu, stall_lsu, mem_req, mem_we;
  logic [1:0] exc_lsu;
  logic [3:0] mem_be;
  int total = 0, bad = 0;
  logic [31:0] held = 0;
  vec_t tbl[14];
  vec_t v;

  lsu_ctrl #(.XLEN(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .valid_lsu(valid_lsu), .opcode_lsu(opcode_lsu),
    .funct3_lsu(funct3_lsu), .addr_lsu(addr_lsu), .wdata_lsu(wdata_lsu),
    .rdata_lsu(rdata_lsu), .done_lsu(done_lsu), .stall_lsu(stall_lsu),
    .exc_lsu(exc_lsu), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Expected results from the access rules, byte by byte; rd is the value rdata_lsu holds afterwards.
  task automatic predict(inout vec_t p);
    bit ld, st, ok, neg;
    int size, off;
    ld = p.op == LD;
    st = p.op == ST;
    case (p.f3)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      default: size = 4;
    endcase
    ok = ld ? p.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5} : p.f3 inside {3'd0, 3'd1, 3'd2};
    off = int'(p.addr % 4);
    p.be = 0; p.wd = 0; p.rd = held; p.exc = 0; p.nreq = 0; p.done = 0;
    if (!(ld || st)) return;
    if (!ok) begin
      p.exc = 3; p.done = 1;
    end else if (p.addr % size != 0) begin
      p.exc = 1; p.done = 1;
    end else begin
      for (int i = off; i < off + size; i++) p.be[i] = 1'b1;
      for (int i = 0; i < size; i++) p.wd[8*(off+i) +: 8] = p.wdata[8*i +: 8];
      if (p.delay > TO) begin
        p.exc = 2; p.nreq = TO + 1; p.done = TO + 2;
      end else begin
        p.nreq = p.delay + 1; p.done = p.delay + 2;
        if (ld) begin
          neg = p.f3 < 4 && p.rdata[8*(off+size)-1];
          for (int i = 0; i < 4; i++)
            p.rd[8*i +: 8] = i < size ? p.rdata[8*(off+i) +: 8] : (neg ? 8'hFF : 8'h00);
        end
      end
    end
  endtask

  task automatic run_op(input vec_t p);
    int nreq, done_at;
    logic [3:0] be;
    logic [31:0] ma, wd;
    logic we, st_k, st_d;
    logic [1:0] ex;
    nreq = 0; done_at = 0; be = 0; ma = 0; wd = 0; we = 0; st_d = 0; ex = 0;
    @(posedge clk); #1;
    valid_lsu = 1; opcode_lsu = p.op; funct3_lsu = p.f3; addr_lsu = p.addr; wdata_lsu = p.wdata;
    @(negedge clk);
    st_k = stall_lsu;
    for (int c = 1; c <= 12 && done_at == 0; c++) begin
      @(posedge clk); #1;
      valid_lsu = 0; addr_lsu = $urandom; wdata_lsu = $urandom;
      mem_ack = c == p.delay + 1;
      mem_rdata = mem_ack ? p.rdata : $urandom;
      @(negedge clk);
      if (mem_req) begin
        nreq++; be = mem_be; ma = mem_addr; wd = mem_wdata; we = mem_we;
      end
      if (done_lsu) begin
        done_at = c; ex = exc_lsu; st_d = stall_lsu;
      end
    end
    mem_ack = 0;
    chk("stall_k", 32'(st_k), 32'(p.op == LD || p.op == ST));
    chk("nreq", nreq, p.nreq);
    chk("done_at", done_at, p.done);
    if (p.done > 0) begin
      chk("exc", 32'(ex), 32'(p.exc));
      chk("stall_done", 32'(st_d), 0);
    end
    if (p.nreq > 0) begin
      chk("be", 32'(be), 32'(p.be));
      chk("maddr", ma, p.addr & ~32'h3);
      chk("we", 32'(we), 32'(p.op == ST));
      if (p.op == ST) chk("wdata", wd, p.wd);
    end
    chk("rdata", rdata_lsu, p.rd);
    held = p.rd;
  endtask

  initial begin
    tbl[0]  = '{ST,  3'd2, 32'h104, 32'hDEADBEEF, 32'h0,        2,  4'hF, 32'hDEADBEEF, 32'h0,        2'd0, 3, 4};
    tbl[1]  = '{LD,  3'd0, 32'h103, 32'h0,        32'h80123456, 0,  4'h8, 32'h0,        32'hFFFFFF80, 2'd0, 1, 2};
    tbl[2]  = '{LD,  3'd4, 32'h103, 32'h0,        32'h80123456, 0,  4'h8, 32'h0,        32'h00000080, 2'd0, 1, 2};
    tbl[3]  = '{LD,  3'd5, 32'h102, 32'h0,        32'hBEEF1234, 0,  4'hC, 32'h0,        32'h0000BEEF, 2'd0, 1, 2};
    tbl[4]  = '{ST,  3'd1, 32'h102, 32'h0000ABCD, 32'h0,        1,  4'hC, 32'hABCD0000, 32'h0000BEEF, 2'd0, 2, 3};
    tbl[5]  = '{LD,  3'd2, 32'h102, 32'h0,        32'h0,        0,  4'h0, 32'h0,        32'h0000BEEF, 2'd1, 0, 1};
    tbl[6]  = '{LD,  3'd7, 32'h100, 32'h0,        32'h0,        0,  4'h0, 32'h0,        32'h0000BEEF, 2'd3, 0, 1};
    tbl[7]  = '{LD,  3'd2, 32'h200, 32'h0,        32'h0,        99, 4'hF, 32'h0,        32'h0000BEEF, 2'd2, 5, 6};
    tbl[8]  = '{LD,  3'd2, 32'h200, 32'h0,        32'h12345678, 4,  4'hF, 32'h0,        32'h12345678, 2'd0, 5, 6};
    tbl[9]  = '{ST,  3'd4, 32'h100, 32'h0,        32'h0,        0,  4'h0, 32'h0,        32'h12345678, 2'd3, 0, 1};
    tbl[10] = '{LD,  3'd1, 32'h102, 32'h0,        32'h80015555, 0,  4'hC, 32'h0,        32'hFFFF8001, 2'd0, 1, 2};
    tbl[11] = '{ADD, 3'd0, 32'h104, 32'h0,        32'h0,        0,  4'h0, 32'h0,        32'hFFFF8001, 2'd0, 0, 0};
    tbl[12] = '{LD,  3'd1, 32'h101, 32'h0,        32'h0,        0,  4'h0, 32'h0,        32'hFFFF8001, 2'd1, 0, 1};
    tbl[13] = '{ST,  3'd0, 32'h101, 32'h12345677, 32'h0,        1,  4'h2, 32'h00007700, 32'hFFFF8001, 2'd0, 2, 3};
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_be", 32'(mem_be), 0);
    chk("rst_rdata", rdata_lsu, 0);
    chk("rst_exc", 32'(exc_lsu), 0);
    chk("rst_done", 32'(done_lsu), 0);
    chk("rst_bus", mem_addr | mem_wdata | 32'(mem_we), 0);
    for (int i = 0; i < 14; i++) run_op(tbl[i]);
    // Abort an access with reset in its second wait cycle.
    @(posedge clk); #1;
    valid_lsu = 1; opcode_lsu = LD; funct3_lsu = 3'd2; addr_lsu = 32'h300;
    @(posedge clk); #1 valid_lsu = 0;
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("abort_req", 32'(mem_req), 0);
    chk("abort_rdata", rdata_lsu, 0);
    chk("abort_be", 32'(mem_be), 0);
    chk("abort_stall", 32'(stall_lsu), 0);
    begin
      int nd = 0;
      if (done_lsu) nd++;
      repeat (4) begin
        @(negedge clk);
        if (done_lsu || mem_req) nd++;
      end
      chk("abort_quiet", nd, 0);
    end
    held = 0;
    v = '{LD, 3'd2, 32'h400, 32'h0, 32'hCAFEF00D, 1, 4'h0, 32'h0, 32'h0, 2'd0, 0, 0};
    predict(v);
    run_op(v);
    for (int n = 0; n < 150; n++) begin
      int r;
      r = $urandom_range(0, 4);
      v.op = r < 2 ? LD : r < 4 ? ST : (r[0] ? ADD : 7'h13);
      v.f3 = 3'($urandom_range(0, 7));
      v.addr = $urandom;
      v.wdata = $urandom;
      v.rdata = $urandom;
      v.delay = $urandom_range(0, 6);
      predict(v);
      run_op(v);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Parametrised load/store unit controller, the sequential successor to the single-cycle load/store opcode decoder. Sits in the execute/memory stage between the core pipeline and the data-memory bus. Decodes the instruction, checks alignment and width, runs a req/ack handshake with data memory (with a wait-state timeout), and returns a lane-extracted, sign- or zero-extended load result. Stalls the pipeline for the duration of the access.

## Interface
- XLEN, 32: data/address width; legal values 32 or 64.
- TIMEOUT, 15: wait cycles in REQ without `mem_ack` before a bus-timeout exception; 0 disables the timeout.

- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- valid_lsu  in  1  instruction valid at stage input
- opcode_lsu  in  7  instruction opcode
- funct3_lsu  in  3  access width/sign field
- addr_lsu  in  XLEN  effective byte address (rs1+imm)
- wdata_lsu  in  XLEN  store data (rs2)
- rdata_lsu  out  XLEN  extended load result
- done_lsu  out  1  one-cycle completion pulse
- stall_lsu  out  1  hold pipeline
- exc_lsu  out  2  00 none, 01 misaligned, 10 bus timeout, 11 illegal width; valid when `done_lsu`=1
- mem_req  out  1  bus request
- mem_we  out  1  1 = store
- mem_addr  out  XLEN  address with low log2(XLEN/8) bits cleared
- mem_be  out  XLEN/8  byte enables
- mem_wdata  out  XLEN  lane-shifted store data
- mem_rdata  in  XLEN  read data, valid with `mem_ack`
- mem_ack  in  1  bus acknowledge

## Operation
- Memory ops: opcode 0000011 is a load, 0100011 is a store. Any other opcode is a non-memory op: no access, no stall, no done.
- Widths: funct3 000 B, 001 H, 010 W, 100 BU, 101 HU, all for loads. Stores use 000/001/010.
- XLEN=64 additionally allows 011 D (load/store) and 110 WU (load). Every other combination gives exc 11.
- Misaligned: H with addr[0]≠0; W with addr[1:0]≠0; D with addr[2:0]≠0. Gives exc 01.
- Lanes: off = addr mod (XLEN/8).
  - mem_be = size mask << off.
  - mem_wdata = wdata low size bytes << 8·off.
  - Load: (mem_rdata >> 8·off) truncated to size, then sign-extended (B/H/W/D) or zero-extended (BU/HU/WU).
- FSM states: IDLE, REQ, DONE, ERR.
  - IDLE: on valid_lsu & memory op, capture addr, data, width and type into registers. Go to ERR if illegal or misaligned, else go to REQ.
  - REQ: mem_req=1, with mem_we/addr/be/wdata stable from the registers. On mem_ack, go to DONE and register the extracted load data (stores do not update rdata_lsu). Without ack, wait counter increments; when counter = TIMEOUT (TIMEOUT>0), go to ERR with exc 10.
  - DONE: done_lsu=1, exc_lsu=00, then go to IDLE.
  - ERR: done_lsu=1, exc_lsu=captured code, no bus access ever issued for 01/11; then go to IDLE.
- stall_lsu = (IDLE & valid_lsu & memory op) | REQ. stall_lsu is 0 in DONE/ERR so the pipeline advances on the done cycle.
- valid_lsu is sampled only in IDLE. mem_ack outside REQ is ignored.
- rdata_lsu holds its value until the next successful load.

## Timing
- Reset: state IDLE, counter 0; all outputs 0, including rdata_lsu, mem_be and exc_lsu.
- Reset mid-access: at the reset edge the state returns to IDLE and mem_req is 0 in the next cycle; no done pulse is produced for the aborted access.
- Latency with valid in cycle k:
  - REQ in k+1.
  - With ack in k+1, done in k+2 (minimum 2 cycles).
  - Each wait cycle adds 1.
  - Error path: done in k+1.
- Timeout: mem_req is high for exactly TIMEOUT+1 cycles, then ERR.
- Ack arriving in the same cycle the counter reaches TIMEOUT: the ack wins (DONE).
- mem_* outputs are registered or derived from the capture registers only, with no combinational path from inputs to the bus.

## Test plan
- SW addr 0x104, wdata 0xDEADBEEF, ack after 2 wait cycles -> mem_be=1111, mem_wdata=0xDEADBEEF, mem_we=1, mem_req high for 3 cycles, done at k+4, exc 00.
- LB addr 0x103, mem_rdata 0x80123456 -> mem_be=1000, mem_addr=0x100, rdata_lsu=0xFFFFFF80. LBU with the same stimulus -> 0x00000080.
- LHU addr 0x102, mem_rdata 0xBEEF1234 -> mem_be=1100, rdata_lsu=0x0000BEEF. SH addr 0x102, wdata 0x0000ABCD -> mem_wdata=0xABCD0000.
- LW addr 0x102 -> no mem_req, done at k+1 with exc 01. Load with funct3 111 -> exc 11. ADD opcode with valid -> stall 0, no done.
- TIMEOUT=4, no ack -> mem_req high 5 cycles, done with exc 10. Ack in the 5th cycle -> exc 00.
- rst asserted during REQ -> next cycle mem_req=0, all outputs 0, no done pulse. A following LW completes normally.
